// File: rtl/writeback_stage_if.sv
// ============================================================================
// Module   : writeback_stage_if
// Brief    : Execute-to-writeback handshake, register-file port, EFLAGS and
//            forwarding bundle for the writeback stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface writeback_stage_if;
  logic        ex_v;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_flags;
  logic [31:0] ex_flags_mask;
  logic        ex_wr_en;
  logic [2:0]  ex_dreg;
  logic [1:0]  ex_dsize;
  logic        flush;
  logic        wb_stall;
  logic        wb_reg_we;
  logic [2:0]  wb_reg_addr;
  logic [3:0]  wb_reg_be;
  logic [31:0] wb_reg_data;
  logic [31:0] eflags;
  logic        fwd_v;
  logic [2:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [1:0]  count;

  // Driver side (execute stage / environment)
  modport master (
    output ex_v, ex_result, ex_flags, ex_flags_mask, ex_wr_en, ex_dreg,
           ex_dsize, flush, wb_stall,
    input  ex_ready, wb_reg_we, wb_reg_addr, wb_reg_be, wb_reg_data, eflags,
           fwd_v, fwd_reg, fwd_data, count
  );

  // Writeback stage side
  modport slave (
    input  ex_v, ex_result, ex_flags, ex_flags_mask, ex_wr_en, ex_dreg,
           ex_dsize, flush, wb_stall,
    output ex_ready, wb_reg_we, wb_reg_addr, wb_reg_be, wb_reg_data, eflags,
           fwd_v, fwd_reg, fwd_data, count
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Brief    : 2-entry skid buffer retiring x86 lane-mapped register writes and
//            masked EFLAGS updates, with youngest-entry forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter logic [31:0] FLAGS_RESET = 32'h0000_0002
) (
  input  wire logic          clk,
  input  wire logic          rst,
  writeback_stage_if.slave   bus
);

  // Bit 1 reads as one; bits 3, 5, 15 and 31:22 read as zero
  localparam logic [31:0] FLAGS_KEEP = 32'h003F_7FD7;
  localparam logic [31:0] FLAGS_ONE  = 32'h0000_0002;

  typedef struct packed {
    logic        wr_en;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] flags;
    logic [31:0] mask;
  } entry_t;

  entry_t      ent_q [2];
  entry_t      new_ent;
  entry_t      head_ent;
  entry_t      young_ent;
  logic        head_q;
  logic        tail_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [31:0] eflags_q;
  logic [31:0] eflags_d;
  logic        has_entry;
  logic        push;
  logic        retire;

  assign has_entry = (count_q != 2'd0);
  assign push      = bus.ex_v & bus.ex_ready & ~bus.flush;
  assign retire    = has_entry & ~bus.wb_stall & ~bus.flush;
  assign head_ent  = ent_q[head_q];
  assign young_ent = ent_q[~tail_q];

  // Lane placement is resolved on entry so retire and forwarding are plain reads
  always_comb begin
    new_ent       = '0;
    new_ent.flags = bus.ex_flags;
    new_ent.mask  = bus.ex_flags_mask;
    new_ent.wr_en = bus.ex_wr_en;
    new_ent.addr  = bus.ex_dreg;
    case (bus.ex_dsize)
      2'b00: begin
        if (bus.ex_dreg[2]) begin
          new_ent.addr = {1'b0, bus.ex_dreg[1:0]};
          new_ent.be   = 4'b0010;
          new_ent.data = {16'b0, bus.ex_result[7:0], 8'b0};
        end else begin
          new_ent.be   = 4'b0001;
          new_ent.data = {24'b0, bus.ex_result[7:0]};
        end
      end
      2'b01: begin
        new_ent.be   = 4'b0011;
        new_ent.data = {16'b0, bus.ex_result[15:0]};
      end
      2'b10: begin
        new_ent.be   = 4'b1111;
        new_ent.data = bus.ex_result;
      end
      default: begin
        new_ent.wr_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, retire};
    eflags_d = ((eflags_q & ~head_ent.mask) | (head_ent.flags & head_ent.mask)
                | FLAGS_ONE) & FLAGS_KEEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      eflags_q <= FLAGS_RESET;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else if (bus.flush) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        ent_q[tail_q] <= new_ent;
        tail_q        <= ~tail_q;
      end
      if (retire) begin
        head_q   <= ~head_q;
        eflags_q <= eflags_d;
      end
    end
  end

  assign bus.ex_ready    = (count_q != 2'd2);
  assign bus.count       = count_q;
  assign bus.eflags      = eflags_q;
  assign bus.wb_reg_we   = retire & head_ent.wr_en;
  assign bus.wb_reg_addr = has_entry ? head_ent.addr : 3'd0;
  assign bus.wb_reg_be   = has_entry ? head_ent.be   : 4'd0;
  assign bus.wb_reg_data = has_entry ? head_ent.data : 32'd0;
  assign bus.fwd_v       = has_entry & young_ent.wr_en;
  assign bus.fwd_reg     = has_entry ? young_ent.addr : 3'd0;
  assign bus.fwd_data    = has_entry ? young_ent.data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Directed self-checking bench for writeback_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  writeback_stage_if bus ();

  writeback_stage #(.FLAGS_RESET(32'h0000_0002)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] r, input logic [31:0] f, input logic [31:0] m,
                       input logic we, input logic [2:0] dreg, input logic [1:0] dsize);
    bus.ex_v          = 1'b1;
    bus.ex_result     = r;
    bus.ex_flags      = f;
    bus.ex_flags_mask = m;
    bus.ex_wr_en      = we;
    bus.ex_dreg       = dreg;
    bus.ex_dsize      = dsize;
  endtask

  task automatic idle();
    bus.ex_v          = 1'b0;
    bus.ex_result     = '0;
    bus.ex_flags      = '0;
    bus.ex_flags_mask = '0;
    bus.ex_wr_en      = 1'b0;
    bus.ex_dreg       = '0;
    bus.ex_dsize      = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.wb_stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_we", 32'(bus.wb_reg_we), 32'd0);
    chk("rst_fwd_v", 32'(bus.fwd_v), 32'd0);
    chk("rst_eflags", bus.eflags, 32'h0000_0002);
    chk("rst_addr", 32'(bus.wb_reg_addr), 32'd0);
    chk("rst_be", 32'(bus.wb_reg_be), 32'd0);
    chk("rst_data", bus.wb_reg_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Dword write with flag update
    drive(32'hDEADBEEF, 32'h041, 32'h8D5, 1'b1, 3'd3, 2'b10);
    tick();
    idle();
    #1;
    chk("dw_we", 32'(bus.wb_reg_we), 32'd1);
    chk("dw_addr", 32'(bus.wb_reg_addr), 32'd3);
    chk("dw_be", 32'(bus.wb_reg_be), 32'hF);
    chk("dw_data", bus.wb_reg_data, 32'hDEADBEEF);
    chk("dw_fwd_reg", 32'(bus.fwd_reg), 32'd3);
    chk("dw_eflags_pre", bus.eflags, 32'h002);
    tick();
    chk("dw_eflags", bus.eflags, 32'h043);
    chk("dw_count", 32'(bus.count), 32'd0);
    chk("dw_we_off", 32'(bus.wb_reg_we), 32'd0);

    // Byte lanes: high byte (dreg 4 -> AH) then low byte (dreg 1)
    drive(32'h1234_56A5, 32'h0, 32'h0, 1'b1, 3'd4, 2'b00);
    tick();
    drive(32'h1234_56A5, 32'h0, 32'h0, 1'b1, 3'd1, 2'b00);
    #1;
    chk("bh_addr", 32'(bus.wb_reg_addr), 32'd0);
    chk("bh_be", 32'(bus.wb_reg_be), 32'b0010);
    chk("bh_data", bus.wb_reg_data, 32'h0000_A500);
    chk("bh_fwd_data", bus.fwd_data, 32'h0000_A500);
    tick();
    idle();
    #1;
    chk("bl_count", 32'(bus.count), 32'd1);
    chk("bl_addr", 32'(bus.wb_reg_addr), 32'd1);
    chk("bl_be", 32'(bus.wb_reg_be), 32'b0001);
    chk("bl_data", bus.wb_reg_data, 32'h0000_00A5);
    tick();
    chk("bl_drain", 32'(bus.count), 32'd0);

    // Stall fills the buffer; release drains in order
    bus.wb_stall = 1'b1;
    drive(32'h1111_1111, 32'h0, 32'h0, 1'b1, 3'd0, 2'b10);
    tick();
    drive(32'h2222_2222, 32'h0, 32'h0, 1'b1, 3'd1, 2'b10);
    tick();
    drive(32'h3333_3333, 32'h0, 32'h0, 1'b1, 3'd2, 2'b10);
    #1;
    chk("st_count", 32'(bus.count), 32'd2);
    chk("st_ready", 32'(bus.ex_ready), 32'd0);
    chk("st_we", 32'(bus.wb_reg_we), 32'd0);
    chk("st_fwd_reg", 32'(bus.fwd_reg), 32'd1);
    tick();
    chk("st_hold_count", 32'(bus.count), 32'd2);
    chk("st_hold_data", bus.wb_reg_data, 32'h1111_1111);
    bus.wb_stall = 1'b0;
    #1;
    chk("rl0_we", 32'(bus.wb_reg_we), 32'd1);
    chk("rl0_addr", 32'(bus.wb_reg_addr), 32'd0);
    chk("rl0_ready", 32'(bus.ex_ready), 32'd0);
    tick();
    chk("rl1_count", 32'(bus.count), 32'd1);
    chk("rl1_ready", 32'(bus.ex_ready), 32'd1);
    chk("rl1_we", 32'(bus.wb_reg_we), 32'd1);
    chk("rl1_data", bus.wb_reg_data, 32'h2222_2222);
    tick();
    idle();
    #1;
    chk("rl2_count", 32'(bus.count), 32'd1);
    chk("rl2_addr", 32'(bus.wb_reg_addr), 32'd2);
    chk("rl2_data", bus.wb_reg_data, 32'h3333_3333);
    tick();
    chk("rl_drain", 32'(bus.count), 32'd0);

    // Flag mask and forced bits
    drive(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'b10);
    tick();
    drive(32'h0, 32'hFFFF_FFFF, 32'h0000_0400, 1'b0, 3'd0, 2'b10);
    tick();
    chk("fl_clear", bus.eflags, 32'h002);
    drive(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'b10);
    tick();
    idle();
    chk("fl_df", bus.eflags, 32'h402);
    tick();
    chk("fl_all0", bus.eflags, 32'h002);

    // Flush with a full buffer and a pending push
    bus.wb_stall = 1'b1;
    drive(32'hAAAA_AAAA, 32'hFFF, 32'hFFFF_FFFF, 1'b1, 3'd5, 2'b10);
    tick();
    tick();
    chk("fx_full", 32'(bus.count), 32'd2);
    bus.flush = 1'b1;
    bus.wb_stall = 1'b0;
    #1;
    chk("fx_we", 32'(bus.wb_reg_we), 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fx_count", 32'(bus.count), 32'd0);
    chk("fx_eflags", bus.eflags, 32'h002);
    chk("fx_ready", 32'(bus.ex_ready), 32'd1);
    idle();
    tick();

    // Reserved size updates flags only
    drive(32'h5555_5555, 32'h001, 32'h001, 1'b1, 3'd5, 2'b11);
    tick();
    idle();
    #1;
    chk("rs_we", 32'(bus.wb_reg_we), 32'd0);
    chk("rs_fwd_v", 32'(bus.fwd_v), 32'd0);
    tick();
    chk("rs_eflags", bus.eflags, 32'h003);

    // Forwarding of youngest entry, then asynchronous reset mid-stall
    bus.wb_stall = 1'b1;
    drive(32'h1234_BEEF, 32'h0, 32'h0, 1'b1, 3'd6, 2'b01);
    tick();
    idle();
    #1;
    chk("fw_v", 32'(bus.fwd_v), 32'd1);
    chk("fw_reg", 32'(bus.fwd_reg), 32'd6);
    chk("fw_data", bus.fwd_data, 32'h0000_BEEF);
    drive(32'h7777_7777, 32'h0, 32'h0, 1'b1, 3'd7, 2'b10);
    tick();
    idle();
    chk("fw_young_reg", 32'(bus.fwd_reg), 32'd7);
    chk("fw_count", 32'(bus.count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(bus.count), 32'd0);
    chk("ar_eflags", bus.eflags, 32'h002);
    chk("ar_ready", 32'(bus.ex_ready), 32'd1);
    chk("ar_fwd_v", 32'(bus.fwd_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.wb_stall = 1'b0;
    tick();
    chk("ar_we", 32'(bus.wb_reg_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
